// File: rtl/exu_lsu_mem_arb.sv
// -----------------------------------------------------------------------------
// exu_lsu_mem_arb
//
// Shares the single LSU data-memory port between the load issue path and the
// store drain path. Requesters are served round-robin with exactly one memory
// transaction outstanding at a time. The memory side uses a req/gnt handshake
// for the address phase followed by an rvalid response (read data or write
// ack). Completed loads are sign/zero extended and written back to the RF; all
// completed ops are reported to the ROB. A global flush kills any pending or
// in-flight op so that it never completes nor writes back.
//
// Ports
//   clk, rst_clk                 clock (posedge) and asynchronous active-high reset
//   rtu_global_flush             kill all in-flight / pending LSU work
//   ld_req_*                     load request: vld/rdy, iid, pdst, addr, size, uns
//   st_req_*                     store request: vld/rdy, iid, addr, size, data
//   mem_req/we/addr/size/wdata   memory request channel (held while waiting gnt)
//   mem_gnt                      memory accepted the request this cycle
//   mem_rvalid/mem_rdata         memory response (right-aligned read data)
//   exu_rtu_rob_lsu_complete/iid one-cycle completion pulse to the ROB
//   exu_idu_rf_lsu_wb_*          one-cycle load writeback pulse to the RF
//
// Size encoding: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 dword (DW = 64).
// Timing: accept in cycle N, mem_req from N+1, gnt earliest N+1, rvalid
// earliest N+2, completion pulse in N+3 (the FSM is already idle in N+3).
// -----------------------------------------------------------------------------
module exu_lsu_mem_arb #(
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int IID_W  = 5,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,

  input  logic              ld_req_vld,
  output logic              ld_req_rdy,
  input  logic [IID_W-1:0]  ld_req_iid,
  input  logic [PREG_W-1:0] ld_req_pdst,
  input  logic [AW-1:0]     ld_req_addr,
  input  logic [1:0]        ld_req_size,
  input  logic              ld_req_uns,

  input  logic              st_req_vld,
  output logic              st_req_rdy,
  input  logic [IID_W-1:0]  st_req_iid,
  input  logic [AW-1:0]     st_req_addr,
  input  logic [1:0]        st_req_size,
  input  logic [DW-1:0]     st_req_data,

  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [1:0]        mem_size,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,

  output logic              exu_rtu_rob_lsu_complete,
  output logic [IID_W-1:0]  exu_rtu_rob_lsu_iid,
  output logic              exu_idu_rf_lsu_wb_vld,
  output logic [PREG_W-1:0] exu_idu_rf_lsu_wb_preg,
  output logic [DW-1:0]     exu_idu_rf_lsu_wb_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Sign/zero extend right-aligned load data to the full register width.
  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] d,
                                                input logic [1:0]    sz,
                                                input logic          uns);
    logic [DW-1:0] r;
    case (sz)
      2'b00:   r = {{(DW-8){~uns & d[7]}},   d[7:0]};
      2'b01:   r = {{(DW-16){~uns & d[15]}}, d[15:0]};
      2'b10:   r = {{(DW-32){~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Keep only the low bytes a store of the given size actually writes.
  function automatic logic [DW-1:0] store_pad(input logic [DW-1:0] d,
                                              input logic [1:0]    sz);
    logic [DW-1:0] r;
    case (sz)
      2'b00:   r = {{(DW-8){1'b0}},  d[7:0]};
      2'b01:   r = {{(DW-16){1'b0}}, d[15:0]};
      2'b10:   r = {{(DW-32){1'b0}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  state_e              state_q;
  logic                last_st_q;   // 1 = store was granted last, load wins next tie
  logic                kill_q;      // in-flight op was flushed, swallow its response
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [DW-1:0]       wdata_q;
  logic [IID_W-1:0]    iid_q;
  logic [PREG_W-1:0]   pdst_q;

  logic                cpl_q;
  logic [IID_W-1:0]    cpl_iid_q;
  logic                wb_vld_q;
  logic [PREG_W-1:0]   wb_preg_q;
  logic [DW-1:0]       wb_data_q;

  logic                ld_win_d;
  logic                st_win_d;
  logic [DW-1:0]       st_wdata_d;
  logic [DW-1:0]       ld_wb_data_d;
  logic                req_phase_d;

  assign st_wdata_d   = store_pad(st_req_data, st_req_size);
  assign ld_wb_data_d = load_extend(mem_rdata, size_q, uns_q);

  // Round-robin winner; only offered while idle and not being flushed.
  always_comb begin
    ld_win_d = 1'b0;
    st_win_d = 1'b0;
    if ((state_q == ST_IDLE) && !rtu_global_flush) begin
      if (ld_req_vld && st_req_vld) begin
        ld_win_d = last_st_q;
        st_win_d = ~last_st_q;
      end else begin
        ld_win_d = ld_req_vld;
        st_win_d = st_req_vld;
      end
    end else begin
      ld_win_d = 1'b0;
      st_win_d = 1'b0;
    end
  end

  assign ld_req_rdy = ld_win_d;
  assign st_req_rdy = st_win_d;

  // Memory request fields come straight from flops and read as zero outside REQ.
  assign req_phase_d = (state_q == ST_REQ);
  assign mem_req     = req_phase_d;
  assign mem_we      = req_phase_d & we_q;
  assign mem_addr    = req_phase_d ? addr_q  : {AW{1'b0}};
  assign mem_size    = req_phase_d ? size_q  : 2'b00;
  assign mem_wdata   = req_phase_d ? wdata_q : {DW{1'b0}};

  assign exu_rtu_rob_lsu_complete = cpl_q;
  assign exu_rtu_rob_lsu_iid      = cpl_iid_q;
  assign exu_idu_rf_lsu_wb_vld    = wb_vld_q;
  assign exu_idu_rf_lsu_wb_preg   = wb_preg_q;
  assign exu_idu_rf_lsu_wb_data   = wb_data_q;

  // Transaction FSM, latched op fields and registered ROB/RF pulses.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      state_q   <= ST_IDLE;
      last_st_q <= 1'b1;
      kill_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {AW{1'b0}};
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= {DW{1'b0}};
      iid_q     <= {IID_W{1'b0}};
      pdst_q    <= {PREG_W{1'b0}};
      cpl_q     <= 1'b0;
      cpl_iid_q <= {IID_W{1'b0}};
      wb_vld_q  <= 1'b0;
      wb_preg_q <= {PREG_W{1'b0}};
      wb_data_q <= {DW{1'b0}};
    end else begin
      // Pulses are single-cycle: cleared unless a response completes below.
      cpl_q     <= 1'b0;
      cpl_iid_q <= {IID_W{1'b0}};
      wb_vld_q  <= 1'b0;
      wb_preg_q <= {PREG_W{1'b0}};
      wb_data_q <= {DW{1'b0}};

      case (state_q)
        ST_IDLE: begin
          kill_q <= 1'b0;
          if (ld_win_d) begin
            we_q      <= 1'b0;
            addr_q    <= ld_req_addr;
            size_q    <= ld_req_size;
            uns_q     <= ld_req_uns;
            wdata_q   <= {DW{1'b0}};
            iid_q     <= ld_req_iid;
            pdst_q    <= ld_req_pdst;
            last_st_q <= 1'b0;
            state_q   <= ST_REQ;
          end else if (st_win_d) begin
            we_q      <= 1'b1;
            addr_q    <= st_req_addr;
            size_q    <= st_req_size;
            uns_q     <= 1'b0;
            wdata_q   <= st_wdata_d;
            iid_q     <= st_req_iid;
            pdst_q    <= {PREG_W{1'b0}};
            last_st_q <= 1'b1;
            state_q   <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_REQ: begin
          if (mem_gnt) begin
            // Once granted the memory will respond, so a coincident flush
            // must still wait for rvalid, just silently.
            state_q <= ST_WAIT;
            kill_q  <= rtu_global_flush;
          end else if (rtu_global_flush) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
          end else begin
            state_q <= ST_REQ;
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
            if (!kill_q && !rtu_global_flush) begin
              cpl_q     <= 1'b1;
              cpl_iid_q <= iid_q;
              if (!we_q) begin
                wb_vld_q  <= 1'b1;
                wb_preg_q <= pdst_q;
                wb_data_q <= ld_wb_data_d;
              end else begin
                wb_vld_q  <= 1'b0;
              end
            end else begin
              cpl_q <= 1'b0;
            end
          end else if (rtu_global_flush) begin
            kill_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_lsu_mem_arb.sv
module tb_exu_lsu_mem_arb;
  localparam int AW = 64, DW = 64, IID_W = 5, PREG_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_clk, rtu_global_flush;
  logic              ld_req_vld, ld_req_rdy, ld_req_uns;
  logic [IID_W-1:0]  ld_req_iid;
  logic [PREG_W-1:0] ld_req_pdst;
  logic [AW-1:0]     ld_req_addr;
  logic [1:0]        ld_req_size;
  logic              st_req_vld, st_req_rdy;
  logic [IID_W-1:0]  st_req_iid;
  logic [AW-1:0]     st_req_addr;
  logic [1:0]        st_req_size;
  logic [DW-1:0]     st_req_data;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0]     mem_addr;
  logic [1:0]        mem_size;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              exu_rtu_rob_lsu_complete, exu_idu_rf_lsu_wb_vld;
  logic [IID_W-1:0]  exu_rtu_rob_lsu_iid;
  logic [PREG_W-1:0] exu_idu_rf_lsu_wb_preg;
  logic [DW-1:0]     exu_idu_rf_lsu_wb_data;

  exu_lsu_mem_arb #(.AW(AW), .DW(DW), .IID_W(IID_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
    .ld_req_vld(ld_req_vld), .ld_req_rdy(ld_req_rdy), .ld_req_iid(ld_req_iid),
    .ld_req_pdst(ld_req_pdst), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
    .ld_req_uns(ld_req_uns),
    .st_req_vld(st_req_vld), .st_req_rdy(st_req_rdy), .st_req_iid(st_req_iid),
    .st_req_addr(st_req_addr), .st_req_size(st_req_size), .st_req_data(st_req_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .exu_rtu_rob_lsu_complete(exu_rtu_rob_lsu_complete), .exu_rtu_rob_lsu_iid(exu_rtu_rob_lsu_iid),
    .exu_idu_rf_lsu_wb_vld(exu_idu_rf_lsu_wb_vld), .exu_idu_rf_lsu_wb_preg(exu_idu_rf_lsu_wb_preg),
    .exu_idu_rf_lsu_wb_data(exu_idu_rf_lsu_wb_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model state for the random phase
  bit                busy, in_req, in_wait, pulse_due, pulse_ld, last_st, exp_ld, exp_st;
  int                gnt_wait, rsp_wait;
  logic              op_we, op_uns;
  logic [63:0]       op_addr, op_wdata, pulse_data;
  logic [1:0]        op_size;
  logic [IID_W-1:0]  op_iid, pulse_iid;
  logic [PREG_W-1:0] op_pdst, pulse_preg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Respond to a request in its first REQ cycle: gnt now, rvalid next cycle.
  task automatic serve(input logic [63:0] rd);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
  endtask

  function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [1:0] sz, input logic uns);
    int sh;
    sh = 64 - (8 << sz);
    if (uns) return (d << sh) >> sh;
    else     return $signed(d << sh) >>> sh;
  endfunction

  function automatic logic [63:0] ref_pad(input logic [63:0] d, input logic [1:0] sz);
    int sh;
    sh = 64 - (8 << sz);
    return (d << sh) >> sh;
  endfunction

  initial begin
    rst_clk = 1'b1; rtu_global_flush = 1'b0;
    ld_req_vld = 1'b0; ld_req_iid = '0; ld_req_pdst = '0; ld_req_addr = '0; ld_req_size = 2'b00; ld_req_uns = 1'b0;
    st_req_vld = 1'b0; st_req_iid = '0; st_req_addr = '0; st_req_size = 2'b00; st_req_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick(); settle();
    chk("rst_mem_req", mem_req, 64'd0);
    chk("rst_ld_rdy", ld_req_rdy, 64'd0);
    chk("rst_st_rdy", st_req_rdy, 64'd0);
    chk("rst_complete", exu_rtu_rob_lsu_complete, 64'd0);
    chk("rst_wb_vld", exu_idu_rf_lsu_wb_vld, 64'd0);
    chk("rst_wb_data", exu_idu_rf_lsu_wb_data, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    tick();
    rst_clk = 1'b0;
    tick();

    // Signed byte load, immediate gnt, rvalid one cycle later
    ld_req_vld = 1'b1; ld_req_size = 2'b00; ld_req_uns = 1'b0; ld_req_addr = 64'h1000;
    ld_req_iid = 5'd3; ld_req_pdst = 6'd7;
    settle();
    chk("ldb_ld_rdy", ld_req_rdy, 64'd1);
    chk("ldb_st_rdy", st_req_rdy, 64'd0);
    tick();
    ld_req_vld = 1'b0; mem_gnt = 1'b1;
    settle();
    chk("ldb_mem_req", mem_req, 64'd1);
    chk("ldb_mem_we", mem_we, 64'd0);
    chk("ldb_mem_addr", mem_addr, 64'h1000);
    chk("ldb_mem_size", mem_size, 64'd0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h80;
    settle();
    chk("ldb_req_drop", mem_req, 64'd0);
    chk("ldb_early_cpl", exu_rtu_rob_lsu_complete, 64'd0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("ldb_complete", exu_rtu_rob_lsu_complete, 64'd1);
    chk("ldb_iid", exu_rtu_rob_lsu_iid, 64'd3);
    chk("ldb_wb_vld", exu_idu_rf_lsu_wb_vld, 64'd1);
    chk("ldb_wb_preg", exu_idu_rf_lsu_wb_preg, 64'd7);
    chk("ldb_wb_data", exu_idu_rf_lsu_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    tick(); settle();
    chk("ldb_pulse_len", exu_rtu_rob_lsu_complete, 64'd0);
    chk("ldb_wb_len", exu_idu_rf_lsu_wb_vld, 64'd0);

    // Word store
    st_req_vld = 1'b1; st_req_size = 2'b10; st_req_data = 64'h1234_5678_9ABC_DEF0;
    st_req_addr = 64'h2000; st_req_iid = 5'd9;
    settle();
    chk("stw_st_rdy", st_req_rdy, 64'd1);
    chk("stw_ld_rdy", ld_req_rdy, 64'd0);
    tick();
    st_req_vld = 1'b0; mem_gnt = 1'b1;
    settle();
    chk("stw_mem_we", mem_we, 64'd1);
    chk("stw_mem_wdata", mem_wdata, 64'h9ABC_DEF0);
    chk("stw_mem_size", mem_size, 64'd2);
    chk("stw_mem_addr", mem_addr, 64'h2000);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("stw_complete", exu_rtu_rob_lsu_complete, 64'd1);
    chk("stw_iid", exu_rtu_rob_lsu_iid, 64'd9);
    chk("stw_wb_vld", exu_idu_rf_lsu_wb_vld, 64'd0);
    chk("stw_wb_data", exu_idu_rf_lsu_wb_data, 64'd0);
    tick();

    // Both valid every cycle: grants alternate, load first
    ld_req_vld = 1'b1; st_req_vld = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("alt_ld_rdy", ld_req_rdy, 64'((k % 2) == 0));
      chk("alt_st_rdy", st_req_rdy, 64'((k % 2) == 1));
      tick();
      mem_gnt = 1'b1;
      settle();
      chk("alt_busy_rdy", ld_req_rdy | st_req_rdy, 64'd0);
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
    end
    ld_req_vld = 1'b0; st_req_vld = 1'b0;
    tick();

    // gnt held low for 5 cycles: request stable, no rdy
    st_req_vld = 1'b1; st_req_size = 2'b01; st_req_data = 64'hAAAA_BBBB_CCCC_1234;
    st_req_addr = 64'h3008; st_req_iid = 5'd4;
    settle();
    chk("stall_st_rdy", st_req_rdy, 64'd1);
    tick();
    st_req_vld = 1'b0; ld_req_vld = 1'b1; ld_req_size = 2'b01; ld_req_uns = 1'b1;
    ld_req_iid = 5'd21; ld_req_pdst = 6'd33; ld_req_addr = 64'h4000;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_mem_req", mem_req, 64'd1);
      chk("stall_mem_addr", mem_addr, 64'h3008);
      chk("stall_mem_wdata", mem_wdata, 64'h1234);
      chk("stall_mem_size", mem_size, 64'd1);
      chk("stall_mem_we", mem_we, 64'd1);
      chk("stall_rdy", ld_req_rdy | st_req_rdy, 64'd0);
      tick();
    end
    serve(64'h0);
    settle();
    chk("stall_complete", exu_rtu_rob_lsu_complete, 64'd1);
    chk("stall_iid", exu_rtu_rob_lsu_iid, 64'd4);
    chk("overlap_ld_rdy", ld_req_rdy, 64'd1);
    tick();
    ld_req_vld = 1'b0;
    serve(64'h1234_5678_9ABC_8001);
    settle();
    chk("ldh_complete", exu_rtu_rob_lsu_complete, 64'd1);
    chk("ldh_wb_data", exu_idu_rf_lsu_wb_data, 64'h8001);
    chk("ldh_wb_preg", exu_idu_rf_lsu_wb_preg, 64'd33);
    tick();

    // Flush while waiting for the response
    ld_req_vld = 1'b1; ld_req_size = 2'b11; ld_req_uns = 1'b0; ld_req_iid = 5'd11; ld_req_pdst = 6'd12;
    settle();
    chk("flw_ld_rdy", ld_req_rdy, 64'd1);
    tick();
    ld_req_vld = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rtu_global_flush = 1'b1;
    tick();
    rtu_global_flush = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h5555;
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("flw_complete", exu_rtu_rob_lsu_complete, 64'd0);
    chk("flw_wb_vld", exu_idu_rf_lsu_wb_vld, 64'd0);
    tick(); settle();
    chk("flw_complete2", exu_rtu_rob_lsu_complete, 64'd0);
    ld_req_vld = 1'b1; ld_req_size = 2'b10; ld_req_uns = 1'b0; ld_req_iid = 5'd13; ld_req_pdst = 6'd14;
    settle();
    chk("flw_idle_rdy", ld_req_rdy, 64'd1);
    tick();
    ld_req_vld = 1'b0;
    serve(64'h1111_2222_8000_0001);
    settle();
    chk("flw_next_cpl", exu_rtu_rob_lsu_complete, 64'd1);
    chk("flw_next_iid", exu_rtu_rob_lsu_iid, 64'd13);
    chk("flw_next_data", exu_idu_rf_lsu_wb_data, 64'hFFFF_FFFF_8000_0001);
    chk("flw_next_preg", exu_idu_rf_lsu_wb_preg, 64'd14);
    tick();

    // Flush in REQ without gnt, stray rvalid, rdy masked by flush
    ld_req_vld = 1'b1; ld_req_iid = 5'd15;
    settle();
    tick();
    ld_req_vld = 1'b0; rtu_global_flush = 1'b1;
    settle();
    chk("flr_mem_req", mem_req, 64'd1);
    tick();
    rtu_global_flush = 1'b0;
    settle();
    chk("flr_req_drop", mem_req, 64'd0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("flr_no_cpl", exu_rtu_rob_lsu_complete, 64'd0);
    tick(); settle();
    chk("flr_no_cpl2", exu_rtu_rob_lsu_complete, 64'd0);
    ld_req_vld = 1'b1; rtu_global_flush = 1'b1;
    settle();
    chk("flr_flush_rdy", ld_req_rdy, 64'd0);
    rtu_global_flush = 1'b0;
    settle();
    chk("flr_idle_rdy", ld_req_rdy, 64'd1);
    ld_req_vld = 1'b0;
    tick();

    // Reset pulse while waiting for the response
    ld_req_vld = 1'b1; ld_req_iid = 5'd17; ld_req_pdst = 6'd18; ld_req_addr = 64'h5000;
    settle();
    tick();
    ld_req_vld = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rst_clk = 1'b1;
    settle();
    chk("rsw_mem_req", mem_req, 64'd0);
    chk("rsw_mem_addr", mem_addr, 64'd0);
    chk("rsw_complete", exu_rtu_rob_lsu_complete, 64'd0);
    chk("rsw_wb_vld", exu_idu_rf_lsu_wb_vld, 64'd0);
    chk("rsw_wb_data", exu_idu_rf_lsu_wb_data, 64'd0);
    tick();
    rst_clk = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("rsw_no_cpl", exu_rtu_rob_lsu_complete, 64'd0);
    tick();

    // Random traffic against a transaction-level reference model
    busy = 1'b0; in_req = 1'b0; in_wait = 1'b0; pulse_due = 1'b0; pulse_ld = 1'b0; last_st = 1'b1;
    gnt_wait = 0; rsp_wait = 0;
    op_we = 1'b0; op_uns = 1'b0; op_addr = '0; op_wdata = '0; op_size = 2'b00; op_iid = '0; op_pdst = '0;
    pulse_data = '0; pulse_iid = '0; pulse_preg = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!ld_req_vld && $urandom_range(0, 1) == 0) begin
        ld_req_vld  = 1'b1;
        ld_req_iid  = 5'($urandom);
        ld_req_pdst = 6'($urandom);
        ld_req_addr = {$urandom, $urandom};
        ld_req_size = 2'($urandom);
        ld_req_uns  = 1'($urandom);
      end
      if (!st_req_vld && $urandom_range(0, 2) == 0) begin
        st_req_vld  = 1'b1;
        st_req_iid  = 5'($urandom);
        st_req_addr = {$urandom, $urandom};
        st_req_size = 2'($urandom);
        st_req_data = {$urandom, $urandom};
      end
      mem_gnt    = in_req && (gnt_wait == 0);
      mem_rvalid = in_wait && (rsp_wait == 0);
      mem_rdata  = {$urandom, $urandom};
      settle();
      exp_ld = !busy && ld_req_vld && (!st_req_vld || last_st);
      exp_st = !busy && st_req_vld && (!ld_req_vld || !last_st);
      chk("rnd_ld_rdy", ld_req_rdy, 64'(exp_ld));
      chk("rnd_st_rdy", st_req_rdy, 64'(exp_st));
      chk("rnd_mem_req", mem_req, 64'(in_req));
      if (in_req) begin
        chk("rnd_mem_addr", mem_addr, op_addr);
        chk("rnd_mem_we", mem_we, 64'(op_we));
        chk("rnd_mem_size", mem_size, 64'(op_size));
        if (op_we) chk("rnd_mem_wdata", mem_wdata, op_wdata);
      end
      chk("rnd_complete", exu_rtu_rob_lsu_complete, 64'(pulse_due));
      chk("rnd_wb_vld", exu_idu_rf_lsu_wb_vld, 64'(pulse_due && pulse_ld));
      if (pulse_due) begin
        chk("rnd_iid", exu_rtu_rob_lsu_iid, 64'(pulse_iid));
        chk("rnd_wb_data", exu_idu_rf_lsu_wb_data, pulse_data);
        if (pulse_ld) chk("rnd_wb_preg", exu_idu_rf_lsu_wb_preg, 64'(pulse_preg));
      end
      // Advance the model by one clock edge
      pulse_due = 1'b0;
      if (in_wait) begin
        if (mem_rvalid) begin
          in_wait    = 1'b0;
          busy       = 1'b0;
          pulse_due  = 1'b1;
          pulse_iid  = op_iid;
          pulse_ld   = !op_we;
          pulse_preg = op_pdst;
          pulse_data = op_we ? 64'd0 : ref_ext(mem_rdata, op_size, op_uns);
        end else begin
          rsp_wait--;
        end
      end else if (in_req) begin
        if (mem_gnt) begin
          in_req   = 1'b0;
          in_wait  = 1'b1;
          rsp_wait = $urandom_range(0, 2);
        end else begin
          gnt_wait--;
        end
      end
      if (exp_ld) begin
        op_we = 1'b0; op_addr = ld_req_addr; op_size = ld_req_size; op_uns = ld_req_uns;
        op_iid = ld_req_iid; op_pdst = ld_req_pdst; op_wdata = 64'd0;
        busy = 1'b1; in_req = 1'b1; gnt_wait = $urandom_range(0, 3); last_st = 1'b0;
      end else if (exp_st) begin
        op_we = 1'b1; op_addr = st_req_addr; op_size = st_req_size; op_uns = 1'b0;
        op_iid = st_req_iid; op_pdst = '0; op_wdata = ref_pad(st_req_data, st_req_size);
        busy = 1'b1; in_req = 1'b1; gnt_wait = $urandom_range(0, 3); last_st = 1'b1;
      end
      tick();
      if (exp_ld) ld_req_vld = 1'b0;
      if (exp_st) st_req_vld = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
